// File: rtl/clock_mode_ctrl.sv
// ---------------------------------------------------------------------------
// clock_mode_ctrl
//
// Mode controller for a digital clock (HH:MM:SS). In RUN it produces the
// count enables for the seconds/minutes/hours counter chains from the 1 Hz
// tick and the carry flags. Pressing the mode key steps through SET_HR,
// SET_MIN and SET_SEC, where time is frozen and the increment key adjusts
// the selected field. A set state that sees no key for TIMEOUT_S seconds
// returns to RUN on its own.
//
// Parameters
//   TIMEOUT_S  idle seconds in a set state before returning to RUN (1..255)
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   tick_1hz  in   one-cycle pulse once per second
//   key_mode  in   one-cycle debounced pulse, advances mode
//   key_inc   in   one-cycle debounced pulse, adjusts selected field
//   sec_co    in   seconds terminal count (level, seconds = 59)
//   min_co    in   minutes terminal count (level, minutes = 59)
//   sec_en    out  seconds counter enable
//   min_en    out  minutes counter enable
//   hr_en     out  hours counter enable
//   sec_clr   out  synchronous clear request to the seconds counters
//   mode      out  registered state: 00 RUN, 01 SET_HR, 10 SET_MIN, 11 SET_SEC
//   blink     out  display blink phase for the field being set
//
// Key and tick inputs are single-cycle pulses: a high level for one clk
// cycle is one event. There is no back-pressure on any input or output.
// The mode output is the registered state itself and doubles as the FSM
// debug view.
// ---------------------------------------------------------------------------
module clock_mode_ctrl #(
    parameter int TIMEOUT_S = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       sec_co,
    input  logic       min_co,
    output logic       sec_en,
    output logic       min_en,
    output logic       hr_en,
    output logic       sec_clr,
    output logic [1:0] mode,
    output logic       blink
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10,
        ST_SET_SEC = 2'b11
    } state_t;

    // Idle count at which the next tick ends the set state.
    localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT_S - 1);

    state_t     state;
    state_t     state_nx;
    logic [7:0] idle_cnt;
    logic [7:0] idle_nx;
    logic       blink_q;
    logic       blink_nx;

    logic in_set;
    logic any_key;
    logic inc_ok;
    logic timeout;

    assign in_set  = (state != ST_RUN);
    assign any_key = key_mode | key_inc;
    // A mode press in the same cycle swallows the increment press.
    assign inc_ok  = key_inc & ~key_mode;
    // Any key press in the timeout cycle wins over the timeout.
    assign timeout = in_set & tick_1hz & ~any_key & (idle_cnt == IDLE_LAST);

    // -----------------------------------------------------------------------
    // State register (with idle counter and blink phase)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            idle_cnt <= 8'd0;
            blink_q  <= 1'b0;
        end else begin
            state    <= state_nx;
            idle_cnt <= idle_nx;
            blink_q  <= blink_nx;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        if (key_mode) begin
            case (state)
                ST_RUN:     state_nx = ST_SET_HR;
                ST_SET_HR:  state_nx = ST_SET_MIN;
                ST_SET_MIN: state_nx = ST_SET_SEC;
                default:    state_nx = ST_RUN;
            endcase
        end else if (timeout) begin
            state_nx = ST_RUN;
        end

        // Idle counter: restarts on every state entry and every key press,
        // only runs while a field is being set.
        idle_nx = idle_cnt;
        if (state_nx != state || any_key || !in_set) begin
            idle_nx = 8'd0;
        end else if (tick_1hz) begin
            idle_nx = idle_cnt + 8'd1;
        end

        // Blink phase: dark in RUN, lit on entry and on every adjustment so
        // the user sees the new value immediately, else toggles each second.
        blink_nx = blink_q;
        if (state_nx == ST_RUN) begin
            blink_nx = 1'b0;
        end else if (state_nx != state || inc_ok) begin
            blink_nx = 1'b1;
        end else if (tick_1hz) begin
            blink_nx = ~blink_q;
        end
    end

    // -----------------------------------------------------------------------
    // Output decode from the registered state only
    // -----------------------------------------------------------------------
    always_comb begin
        sec_en  = 1'b0;
        min_en  = 1'b0;
        hr_en   = 1'b0;
        sec_clr = 1'b0;
        case (state)
            ST_RUN: begin
                sec_en = tick_1hz;
                min_en = tick_1hz & sec_co;
                hr_en  = tick_1hz & sec_co & min_co;
            end
            // Ticks are deliberately dropped while setting; only the
            // increment key drives the selected field, with no carry.
            ST_SET_HR:  hr_en   = inc_ok;
            ST_SET_MIN: min_en  = inc_ok;
            ST_SET_SEC: sec_clr = inc_ok;
            default: ;
        endcase
    end

    assign mode  = state;
    assign blink = blink_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clock_mode_ctrl
//
// Directed bench for clock_mode_ctrl with TIMEOUT_S = 3. Each step drives
// one cycle of inputs and pushes the outputs expected in that same cycle
// (packed as {mode, blink, sec_en, min_en, hr_en, sec_clr}) onto exp_q; the
// outputs are sampled on the falling edge and compared against the popped
// entry before the rising edge commits the step.
// ---------------------------------------------------------------------------
module tb_clock_mode_ctrl;

    logic       clk;
    logic       rst_n;
    logic       tick_1hz;
    logic       key_mode;
    logic       key_inc;
    logic       sec_co;
    logic       min_co;
    logic       sec_en;
    logic       min_en;
    logic       hr_en;
    logic       sec_clr;
    logic [1:0] mode;
    logic       blink;

    logic [6:0] exp_q[$];
    int         checks;
    int         errors;

    clock_mode_ctrl #(.TIMEOUT_S(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_1hz (tick_1hz),
        .key_mode (key_mode),
        .key_inc  (key_inc),
        .sec_co   (sec_co),
        .min_co   (min_co),
        .sec_en   (sec_en),
        .min_en   (min_en),
        .hr_en    (hr_en),
        .sec_clr  (sec_clr),
        .mode     (mode),
        .blink    (blink)
    );

    // -----------------------------------------------------------------------
    // Clock and watchdog
    // -----------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // -----------------------------------------------------------------------
    // Scoreboard compare: pop the oldest expectation and check the outputs
    // -----------------------------------------------------------------------
    task automatic compare(input string tag);
        logic [6:0] got;
        logic [6:0] exp;
        got = {mode, blink, sec_en, min_en, hr_en, sec_clr};
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got=%b", tag, got);
        end else begin
            exp = exp_q.pop_front();
            checks++;
            assert (got === exp)
            else begin
                errors++;
                $error("FAIL %s: got mode/blink/sec/min/hr/clr=%b expected=%b", tag, got, exp);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    // Driver: one clock cycle of stimulus with its expected outputs
    // -----------------------------------------------------------------------
    task automatic step(input logic t, input logic km, input logic ki,
                        input logic sc, input logic mc,
                        input logic [6:0] exp, input string tag);
        tick_1hz = t;
        key_mode = km;
        key_inc  = ki;
        sec_co   = sc;
        min_co   = mc;
        exp_q.push_back(exp);
        @(negedge clk);
        compare(tag);
        @(posedge clk);
        #1;
    endtask

    // -----------------------------------------------------------------------
    // Directed sequence
    // -----------------------------------------------------------------------
    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        tick_1hz = 1'b0;
        key_mode = 1'b0;
        key_inc  = 1'b0;
        sec_co   = 1'b0;
        min_co   = 1'b0;
        @(posedge clk);
        #1;

        //    tick km ki sc mc   {mode,blink,sec,min,hr,clr}
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b00_0_0000, "reset_idle");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 7'b00_0_1110, "reset_tick_passthru");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'b00_0_0000, "reset_keys_ignored");
        rst_n = 1'b1;

        // RUN decoding and carries
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 7'b00_0_1110, "run_carry_all");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'b00_0_1100, "run_hr_blocked");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b00_0_1000, "run_sec_only");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'b00_0_0000, "run_no_tick");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b00_0_1000, "run_keymode_same_cycle");

        // SET_HR, adjustment and timeout with restart
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b01_1_0000, "enter_set_hr");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b01_1_0010, "set_hr_inc");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 7'b01_1_0000, "set_hr_tick1");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 7'b01_0_0000, "set_hr_tick2");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b01_1_0010, "set_hr_inc_restart");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b01_1_0000, "set_hr_tick1b");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b01_0_0000, "set_hr_tick2b");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b01_1_0000, "set_hr_tick3_timeout");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b00_0_0000, "timeout_back_to_run");

        // Walk modes; SET_MIN adjustments with ticks present
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b00_0_0000, "km_from_run");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b01_1_0000, "km_from_set_hr");
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 7'b10_1_0100, "set_min_inc1_tick");
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 7'b10_1_0100, "set_min_inc2");
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 7'b10_1_0100, "set_min_inc3_tick");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 7'b10_1_0000, "set_min_tick_only");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b10_0_0000, "km_from_set_min");

        // SET_SEC clear, suppressed clear, exit to RUN
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b11_1_0001, "set_sec_clr");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'b11_1_0000, "set_sec_km_ki_suppress");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b00_0_0000, "exit_run_no_sec_en");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b00_0_1000, "first_run_tick");

        // Asynchronous reset while in SET_MIN
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b00_0_0000, "km_to_hr_again");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b01_1_0000, "km_to_min_again");
        key_mode = 1'b0;
        key_inc  = 1'b1;
        tick_1hz = 1'b0;
        exp_q.push_back(7'b10_1_0100);
        #1;
        compare("set_min_before_reset");
        #1;
        rst_n = 1'b0;
        exp_q.push_back(7'b00_0_0000);
        #1;
        compare("async_reset_mid_set");
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b00_0_0000, "reset_held_after_edge");
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b00_0_0000, "after_reset_release");

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_mode_ctrl.md
CLOCK_MODE_CTRL -- requirements
Module: clock_mode_ctrl

Interface
REQ-001 Parameter TIMEOUT_S, default 30, meaning: idle seconds in any set state before automatic return to RUN; legal range 1..255.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 tick_1hz  input  1  one-cycle pulse once per second, synchronous to clk.
REQ-005 key_mode  input  1  debounced one-cycle pulse; advances mode.
REQ-006 key_inc  input  1  debounced one-cycle pulse; adjusts selected field.
REQ-007 sec_co  input  1  seconds-chain terminal-count flag (level, high when seconds = 59).
REQ-008 min_co  input  1  minutes-chain terminal-count flag (level, high when minutes = 59).
REQ-009 sec_en  output  1  count enable to seconds counters.
REQ-010 min_en  output  1  count enable to minutes counters.
REQ-011 hr_en  output  1  count enable to hours counters.
REQ-012 sec_clr  output  1  synchronous clear request to seconds counters.
REQ-013 mode  output  2  current state: 00 RUN, 01 SET_HR, 10 SET_MIN, 11 SET_SEC.
REQ-014 blink  output  1  display blink phase for the field being set.

Function
REQ-015 FSM states RUN, SET_HR, SET_MIN, SET_SEC; mode output SHALL equal the registered state encoding.
REQ-016 key_mode SHALL advance RUN->SET_HR->SET_MIN->SET_SEC->RUN, taking effect on the next clk edge (one-cycle latency).
REQ-017 In RUN: sec_en = tick_1hz; min_en = tick_1hz & sec_co; hr_en = tick_1hz & sec_co & min_co; sec_clr = 0 (combinational, zero latency).
REQ-018 In SET_HR: sec_en = 0, min_en = 0, hr_en = key_inc, sec_clr = 0; time is frozen.
REQ-019 In SET_MIN: sec_en = 0, hr_en = 0, min_en = key_inc, sec_clr = 0; no carry into hours from adjustment.
REQ-020 In SET_SEC: sec_en = 0, min_en = 0, hr_en = 0, sec_clr = key_inc.
REQ-021 Enables SHALL be decoded from the registered state only; a key_mode in the same cycle does not alter the current cycle's outputs.
REQ-022 key_mode and key_inc in the same cycle: mode advance SHALL occur; key_inc SHALL be suppressed (no enable/clear that cycle).
REQ-023 Idle counter, 8 bits: cleared on any key_mode or key_inc, and on entry to any state; increments on tick_1hz while in a set state; held at 0 in RUN.
REQ-024 When idle counter = TIMEOUT_S-1 and tick_1hz arrives with no key that cycle, state SHALL go to RUN on that edge; a key in that cycle SHALL take priority over timeout.
REQ-025 blink register: 0 in RUN; toggles on each tick_1hz in set states; forced to 1 on entry to each set state and on key_inc.
REQ-026 tick_1hz in any set state SHALL NOT produce any count enable (seconds lost while setting, by design).
REQ-027 Exit from SET_SEC to RUN: first RUN sec_en SHALL coincide with the next tick_1hz, not the exit edge.

Reset
REQ-028 rst_n low SHALL immediately force state RUN, idle counter 0, blink 0, independent of clk.
REQ-029 During and after reset all outputs SHALL be: mode 00, blink 0, sec_en/min_en/hr_en follow REQ-017 (0 while tick_1hz low), sec_clr 0.
REQ-030 Reset asserted mid-set SHALL abandon the set state with no pending enable or clear emitted.

Verification
REQ-031 RUN, sec_co=1, min_co=1, tick_1hz pulse -> sec_en, min_en, hr_en all high that single cycle; sec_co=1, min_co=0 -> hr_en low.
REQ-032 Four key_mode pulses from reset -> mode 01, 10, 11, 00 each one cycle after its pulse; blink 1 on each set-state entry.
REQ-033 SET_MIN, three key_inc pulses with tick_1hz also pulsing -> exactly three min_en pulses, zero sec_en/hr_en.
REQ-034 TIMEOUT_S=3, enter SET_HR, no keys -> mode 00 on the edge of the 3rd tick_1hz; key_inc before the 3rd tick restarts the count.
REQ-035 SET_SEC, key_mode and key_inc in same cycle -> sec_clr stays 0, mode becomes 00 next edge.
REQ-036 rst_n pulsed low asynchronously while mode=10 -> mode 00 and blink 0 before next clk edge; no min_en emitted.
